// File: rtl/jt51_pkg.sv
// Shared constants and types for the JT51 CPU write front end.
package jt51_pkg;

  // Global register addresses
  localparam logic [7:0] AddrTest    = 8'h01;
  localparam logic [7:0] AddrKeyon   = 8'h08;
  localparam logic [7:0] AddrNoise   = 8'h0F;
  localparam logic [7:0] AddrClkA1   = 8'h10;
  localparam logic [7:0] AddrClkA2   = 8'h11;
  localparam logic [7:0] AddrClkB    = 8'h12;
  localparam logic [7:0] AddrTimer   = 8'h14;
  localparam logic [7:0] AddrLfoFreq = 8'h18;
  localparam logic [7:0] AddrDepth   = 8'h19;
  localparam logic [7:0] AddrCtWave  = 8'h1B;

  // Slot register group base addresses
  localparam logic [7:0] BaseRl    = 8'h20;
  localparam logic [7:0] BaseKc    = 8'h28;
  localparam logic [7:0] BaseKf    = 8'h30;
  localparam logic [7:0] BasePms   = 8'h38;
  localparam logic [7:0] BaseDt1   = 8'h40;
  localparam logic [7:0] BaseTl    = 8'h60;
  localparam logic [7:0] BaseKs    = 8'h80;
  localparam logic [7:0] BaseAmsen = 8'hA0;
  localparam logic [7:0] BaseDt2   = 8'hC0;
  localparam logic [7:0] BaseD1l   = 8'hE0;

  // Bit positions in the one-hot update-group vector
  localparam int unsigned GrpRl    = 0;
  localparam int unsigned GrpKc    = 1;
  localparam int unsigned GrpKf    = 2;
  localparam int unsigned GrpPms   = 3;
  localparam int unsigned GrpDt1   = 4;
  localparam int unsigned GrpTl    = 5;
  localparam int unsigned GrpKs    = 6;
  localparam int unsigned GrpAmsen = 7;
  localparam int unsigned GrpDt2   = 8;
  localparam int unsigned GrpD1l   = 9;
  localparam int unsigned GrpKeyon = 10;
  localparam int unsigned NumGrp   = 11;

  // Handshake with the slot register stage
  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StSweep
  } hs_state_e;

endpackage

// File: rtl/jt51_wrbus_dec.sv
// Combinational slot-address decoder: one-hot update group plus operator/channel.
module jt51_wrbus_dec
  import jt51_pkg::*;
(
  input  logic [7:0]        addr_i,
  input  logic [7:0]        din_i,
  output logic [NumGrp-1:0] grp_o,
  output logic [1:0]        op_o,
  output logic [2:0]        ch_o
);

  // Map the latched address onto at most one update group
  always_comb begin
    grp_o = '0;
    op_o  = 2'd0;
    ch_o  = addr_i[2:0];
    if (addr_i == AddrKeyon) begin
      grp_o[GrpKeyon] = 1'b1;
      ch_o            = din_i[2:0];
    end else if (addr_i[7:3] == BaseRl[7:3]) begin
      grp_o[GrpRl] = 1'b1;
    end else if (addr_i[7:3] == BaseKc[7:3]) begin
      grp_o[GrpKc] = 1'b1;
    end else if (addr_i[7:3] == BaseKf[7:3]) begin
      grp_o[GrpKf] = 1'b1;
    end else if (addr_i[7:3] == BasePms[7:3]) begin
      grp_o[GrpPms] = 1'b1;
    end else if (addr_i[7:5] == BaseDt1[7:5]) begin
      grp_o[GrpDt1] = 1'b1;
      op_o          = addr_i[4:3];
    end else if (addr_i[7:5] == BaseTl[7:5]) begin
      grp_o[GrpTl] = 1'b1;
      op_o         = addr_i[4:3];
    end else if (addr_i[7:5] == BaseKs[7:5]) begin
      grp_o[GrpKs] = 1'b1;
      op_o         = addr_i[4:3];
    end else if (addr_i[7:5] == BaseAmsen[7:5]) begin
      grp_o[GrpAmsen] = 1'b1;
      op_o            = addr_i[4:3];
    end else if (addr_i[7:5] == BaseDt2[7:5]) begin
      grp_o[GrpDt2] = 1'b1;
      op_o          = addr_i[4:3];
    end else if (addr_i[7:5] == BaseD1l[7:5]) begin
      grp_o[GrpD1l] = 1'b1;
      op_o          = addr_i[4:3];
    end
  end

endmodule

// File: rtl/jt51_wrbus.sv
// JT51 CPU write front end: port decode, global registers, slot-update handshake, status.
module jt51_wrbus
  import jt51_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       reg_busy,
  input  logic       flag_A,
  input  logic       flag_B,
  output logic [7:0] d_in,
  output logic [1:0] op,
  output logic [2:0] ch,
  output logic       up_rl,
  output logic       up_kc,
  output logic       up_kf,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks,
  output logic       up_amsen,
  output logic       up_dt2,
  output logic       up_d1l,
  output logic       up_keyon,
  output logic [7:0] test,
  output logic       ct1,
  output logic       ct2,
  output logic [1:0] lfo_w,
  output logic       noise_en,
  output logic [4:0] nfrq,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       csm,
  output logic       irq_en_B,
  output logic       irq_en_A,
  output logic       load_B,
  output logic       load_A,
  output logic       clr_flag_B,
  output logic       clr_flag_A,
  output logic [7:0] lfo_freq,
  output logic [6:0] amd,
  output logic [6:0] pmd
);

  logic              wr_q;
  logic              wr_act, wr_acc, addr_wr, data_wr, slot_wr, pending;
  logic [7:0]        addr_q;
  logic [NumGrp-1:0] grp, up_q;
  logic [1:0]        dec_op;
  logic [2:0]        dec_ch;
  hs_state_e         state_q;

  // A write is the rising edge of the combined strobe, sampled on every clk
  assign wr_act  = ~cs_n & ~wr_n;
  assign wr_acc  = wr_act & ~wr_q;
  assign addr_wr = wr_acc & ~a0;
  assign data_wr = wr_acc & a0;
  assign slot_wr = data_wr & (|grp);
  assign pending = (state_q != StIdle);
  assign dout    = {pending, 5'b0, flag_B, flag_A};

  jt51_wrbus_dec u_dec (
    .addr_i (addr_q),
    .din_i  (din),
    .grp_o  (grp),
    .op_o   (dec_op),
    .ch_o   (dec_ch)
  );

  // Strobe edge detect and address latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b0;
      addr_q <= 8'h00;
    end else begin
      wr_q <= wr_act;
      if (addr_wr) addr_q <= din;
    end
  end

  // Slot handshake: latch on write, hold until the register stage finishes its sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      up_q    <= '0;
      d_in    <= 8'h00;
      op      <= 2'd0;
      ch      <= 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (slot_wr) begin
            up_q    <= grp;
            d_in    <= din;
            op      <= dec_op;
            ch      <= dec_ch;
            state_q <= StArmed;
          end
        end
        StArmed: if (cen && reg_busy) state_q <= StSweep;
        StSweep: begin
          if (cen && !reg_busy) begin
            up_q    <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign up_rl    = up_q[GrpRl];
  assign up_kc    = up_q[GrpKc];
  assign up_kf    = up_q[GrpKf];
  assign up_pms   = up_q[GrpPms];
  assign up_dt1   = up_q[GrpDt1];
  assign up_tl    = up_q[GrpTl];
  assign up_ks    = up_q[GrpKs];
  assign up_amsen = up_q[GrpAmsen];
  assign up_dt2   = up_q[GrpDt2];
  assign up_d1l   = up_q[GrpD1l];
  assign up_keyon = up_q[GrpKeyon];

  // Global registers update on the accepted clk regardless of busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test       <= 8'h00;
      ct1        <= 1'b0;
      ct2        <= 1'b0;
      lfo_w      <= 2'd0;
      noise_en   <= 1'b0;
      nfrq       <= 5'd0;
      value_A    <= 10'd0;
      value_B    <= 8'h00;
      csm        <= 1'b0;
      irq_en_B   <= 1'b0;
      irq_en_A   <= 1'b0;
      load_B     <= 1'b0;
      load_A     <= 1'b0;
      clr_flag_B <= 1'b0;
      clr_flag_A <= 1'b0;
      lfo_freq   <= 8'h00;
      amd        <= 7'd0;
      pmd        <= 7'd0;
    end else begin
      clr_flag_B <= 1'b0;
      clr_flag_A <= 1'b0;
      if (data_wr) begin
        case (addr_q)
          AddrTest:    test <= din;
          AddrNoise: begin
            noise_en <= din[7];
            nfrq     <= din[4:0];
          end
          AddrClkA1:   value_A[9:2] <= din;
          AddrClkA2:   value_A[1:0] <= din[1:0];
          AddrClkB:    value_B <= din;
          AddrTimer: begin
            csm        <= din[7];
            clr_flag_B <= din[5];
            clr_flag_A <= din[4];
            irq_en_B   <= din[3];
            irq_en_A   <= din[2];
            load_B     <= din[1];
            load_A     <= din[0];
          end
          AddrLfoFreq: lfo_freq <= din;
          AddrDepth: begin
            if (din[7]) pmd <= din[6:0];
            else        amd <= din[6:0];
          end
          AddrCtWave: begin
            ct2   <= din[7];
            ct1   <= din[6];
            lfo_w <= din[1:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/jt51_wrbus.md
Name: jt51_wrbus

Overview:
- CPU-side write front end for the JT51 register file.
- Decodes YM2151 address/data port writes into per-channel/per-operator update strobes (up_*, op, ch, d_in) for the slot register stage; holds them across that stage's 32-slot busy sweep.
- Stores global registers (timers, LFO, noise, CSM, CT pins) locally.
- Returns the status byte on reads.

Parameters:
- none

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cen  in  1  P1 clock enable, same as the register stage
- cs_n  in  1  chip select, active low
- wr_n  in  1  write strobe, active low
- a0  in  1  0 = address port, 1 = data port
- din  in  8  CPU data
- dout  out  8  status {busy,5'b0,flag_B,flag_A}
- reg_busy  in  1  busy from register stage
- flag_A, flag_B  in  1  timer flags
- d_in  out  8  latched data to register stage
- op  out  2  operator, address[4:3]
- ch  out  3  channel
- up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon  out  1 each  update strobes
- test  out  8  reg 0x01; lfo_rst = test[1]
- ct1, ct2  out  1  reg 0x1B bits 6,7
- lfo_w  out  2  reg 0x1B[1:0]
- noise_en  out  1  reg 0x0F[7]
- nfrq  out  5  reg 0x0F[4:0]
- value_A  out  10  {0x10, 0x11[1:0]}
- value_B  out  8  reg 0x12
- csm, irq_en_B, irq_en_A, load_B, load_A  out  1  reg 0x14 bits 7,3,2,1,0
- clr_flag_B, clr_flag_A  out  1  one-clk pulses, reg 0x14 bits 5,4
- lfo_freq  out  8  reg 0x18
- amd, pmd  out  7  reg 0x19; din[7]=1 → pmd, else amd

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All outputs and latches reset to 0; address latch = 0; pending = 0.
- Write acceptance:
  - wr_n and cs_n are sampled every clk (not cen-gated).
  - A write is the first clk where cs_n=0 & wr_n=0 after a clk where that was false. Exactly one action per strobe, however long it is held.
  - a0=0: addr <= din. Always accepted, even while busy.
  - a0=1: data write to addr.
- Global registers (0x01, 0x0F, 0x10-0x12, 0x14, 0x18, 0x19, 0x1B):
  - Updated on the accepted clk, regardless of busy.
  - clr_flag_A/B pulse high for exactly one clk.
  - load_*, irq_en_*, csm are level.
  - Unlisted addresses below 0x20 other than 0x08 are ignored.
- Slot registers, address decode:
  - 0x08 → up_keyon, op=0, ch=din[2:0].
  - 0x20-27 → up_rl; 0x28-2F → up_kc; 0x30-37 → up_kf; 0x38-3F → up_pms. ch=addr[2:0], op=0.
  - 0x40-5F → up_dt1; 0x60-7F → up_tl; 0x80-9F → up_ks; 0xA0-BF → up_amsen; 0xC0-DF → up_dt2; 0xE0-FF → up_d1l. op=addr[4:3], ch=addr[2:0].
- Slot handshake state machine, sampled on cen, states IDLE → ARMED → SWEEP → IDLE:
  - IDLE: accepted slot write → latch d_in/op/ch, assert exactly one up_* strobe, pending=1, go to ARMED.
  - ARMED: hold strobes until reg_busy=1 → SWEEP.
  - SWEEP: hold strobes while reg_busy=1. On cen with reg_busy=0, clear all up_* and pending → IDLE.
  - Strobes are therefore high continuously from the write until the register stage's full 32-slot sweep ends.
- Busy and status:
  - dout[7] = pending (combinational from state).
  - A slot write accepted while pending=1 is dropped; the held outputs are unchanged. This is the YM2151 lost-write behaviour.
- Simultaneous events: a write accepted on the same clk as SWEEP→IDLE sees pending=1 and is dropped.
- Reset mid-sweep: everything clears at once. The register stage is reset by the same rst.

Decomposition:
- Shared package jt51_pkg:
  - address constants for the global registers
  - slot-group base addresses 0x20/0x28/0x30/0x38 and 0x40..0xE0
  - handshake state enum
- One sub-module, jt51_wrbus_dec: purely combinational. Maps addr to a one-hot group vector plus op/ch extraction.

Test Plan:
- Write addr 0x60, data 0x7F → up_tl=1, op=0, ch=0, d_in=0x7F; dout[7]=1 until reg_busy falls; the register stage's tl_VII for slot 0 reads 0x7F on the next sweep.
- Write addr 0x08, data 0x7A → up_keyon=1, ch=2, d_in=0x7A; strobe held ARMED→SWEEP→IDLE, then cleared.
- Write 0x10←0xAB, 0x11←0x03 → value_A=0x2AF. Write 0x14←0x15 → load_A=1, irq_en_A=1, clr_flag_A high for 1 clk.
- While pending, write 0x28←0x4E → dropped, kc unchanged. Write 0x18←0x55 in the same window → lfo_freq=0x55.
- wr_n held low for 10 clk on a data write → single action; 0x19←0x85 → pmd=0x05, amd unchanged.
- Assert rst during SWEEP → all up_*=0, dout=0x00 (flags 0), state IDLE.
